// File: rtl/pref_issue_queue.sv
// pref_issue_queue: line-aligning, duplicate-filtering prefetch issue FIFO.
// Accepts up to three candidates per cycle (slot 1 highest priority) and
// issues one line per cycle over a valid/ready handshake. Lines that are
// already queued, recently issued, or repeated within the same cycle are
// dropped.
// Optional feature: define PREF_ISSUE_QUEUE_STATS_EN to add saturating
// accept/duplicate/full counters (stat_accept_o, stat_dup_o, stat_full_o).
module pref_issue_queue #(
    parameter int DEPTH          = 8,
    parameter int LINE_BITS      = 6,
    parameter int FILTER_ENTRIES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            pref_addr1_i,
    input  logic                   pref_valid1_i,
    input  logic [63:0]            pref_addr2_i,
    input  logic                   pref_valid2_i,
    input  logic [63:0]            pref_addr3_i,
    input  logic                   pref_valid3_i,
    output logic [63:0]            req_addr_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [$clog2(DEPTH):0] count_o
`ifdef PREF_ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]            stat_accept_o,
    output logic [31:0]            stat_dup_o,
    output logic [31:0]            stat_full_o
`endif
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FPTR_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;
    localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_BITS) - 64'd1);

    logic [63:0]               mem_reg [DEPTH];
    logic [PTR_W-1:0]          head_reg;
    logic [PTR_W-1:0]          tail_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [63:0]               filt_line_reg [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] filt_valid_reg;
    logic [FPTR_W-1:0]         filt_ptr_reg;

    logic [63:0]      slot_line [3];
    logic [2:0]       slot_valid;
    logic [2:0]       slot_dup;
    logic [2:0]       slot_accept;
    logic [PTR_W-1:0] slot_wr_idx [3];
    logic [DEPTH-1:0] entry_valid;
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] push_cnt;
    logic             pop;

    assign slot_line[0] = pref_addr1_i & LINE_MASK;
    assign slot_line[1] = pref_addr2_i & LINE_MASK;
    assign slot_line[2] = pref_addr3_i & LINE_MASK;
    assign slot_valid   = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

    // An entry is live when its distance from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
            logic [PTR_W-1:0] off;
            assign off             = PTR_W'(gi) - head_reg;
            assign entry_valid[gi] = {1'b0, off} < count_reg;
        end
    endgenerate

    assign pop = (count_reg != '0) && req_ready_i;

    // Slot classification in priority order: duplicate checks first, then
    // space. Free space is taken from the start-of-cycle count only.
    always_comb begin
        free_cnt    = CNT_W'(DEPTH) - count_reg;
        push_cnt    = '0;
        slot_dup    = '0;
        slot_accept = '0;
        for (int s = 0; s < 3; s++) begin
            slot_wr_idx[s] = tail_reg;
        end
        for (int s = 0; s < 3; s++) begin
            if (slot_valid[s]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (entry_valid[e] && (mem_reg[e] == slot_line[s])) slot_dup[s] = 1'b1;
                end
                for (int f = 0; f < FILTER_ENTRIES; f++) begin
                    if (filt_valid_reg[f] && (filt_line_reg[f] == slot_line[s])) slot_dup[s] = 1'b1;
                end
                for (int p = 0; p < s; p++) begin
                    if (slot_accept[p] && (slot_line[p] == slot_line[s])) slot_dup[s] = 1'b1;
                end
                if (!slot_dup[s] && (push_cnt < free_cnt)) begin
                    slot_accept[s] = 1'b1;
                    slot_wr_idx[s] = tail_reg + push_cnt[PTR_W-1:0];
                    push_cnt       = push_cnt + 1'b1;
                end
            end
        end
    end

    // Pointer, occupancy and filter bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            filt_valid_reg <= '0;
            filt_ptr_reg   <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(pop);
            tail_reg  <= tail_reg + push_cnt[PTR_W-1:0];
            count_reg <= count_reg + push_cnt - CNT_W'(pop);
            if (pop) begin
                filt_valid_reg[filt_ptr_reg] <= 1'b1;
                filt_ptr_reg <= (filt_ptr_reg == FPTR_W'(FILTER_ENTRIES - 1)) ? '0
                                                                             : filt_ptr_reg + 1'b1;
            end
        end
    end

    // Payload storage: queued lines and recently issued lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 3; s++) begin
                if (slot_accept[s]) mem_reg[slot_wr_idx[s]] <= slot_line[s];
            end
            if (pop) filt_line_reg[filt_ptr_reg] <= mem_reg[head_reg];
        end
    end

    assign req_valid_o = (count_reg != '0);
    assign req_addr_o  = req_valid_o ? mem_reg[head_reg] : 64'd0;
    assign count_o     = count_reg;

`ifdef PREF_ISSUE_QUEUE_STATS_EN
    logic [1:0]  acc_n;
    logic [1:0]  dup_n;
    logic [1:0]  full_n;
    logic [31:0] stat_accept_reg;
    logic [31:0] stat_dup_reg;
    logic [31:0] stat_full_reg;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Per-cycle tallies; a full drop is a valid slot that was neither a dup nor accepted.
    always_comb begin
        acc_n  = '0;
        dup_n  = '0;
        full_n = '0;
        for (int s = 0; s < 3; s++) begin
            acc_n  = acc_n + {1'b0, slot_accept[s]};
            dup_n  = dup_n + {1'b0, slot_valid[s] & slot_dup[s]};
            full_n = full_n + {1'b0, slot_valid[s] & ~slot_dup[s] & ~slot_accept[s]};
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accept_reg <= '0;
            stat_dup_reg    <= '0;
            stat_full_reg   <= '0;
        end else begin
            stat_accept_reg <= sat_add(stat_accept_reg, acc_n);
            stat_dup_reg    <= sat_add(stat_dup_reg, dup_n);
            stat_full_reg   <= sat_add(stat_full_reg, full_n);
        end
    end

    assign stat_accept_o = stat_accept_reg;
    assign stat_dup_o    = stat_dup_reg;
    assign stat_full_o   = stat_full_reg;
`endif
endmodule
